// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the multi-port register file.
// Holds the sweep FSM state enum and the write/issue accept predicate.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // A write or issue takes effect only while idle, when enabled,
    // in range, and not aimed at a hardwired-zero register 0.
    function automatic logic accept_ok(
        input logic        idle,
        input logic        en,
        input int unsigned addr,
        input int unsigned num_regs,
        input logic        zero_reg
    );
        return idle && en && (addr < num_regs)
            && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for in-flight producers.
// Ports: clk, rst_n, set_en/set_addr (issue), clr_en/clr_addr (write or
// sweep), lk_addr/lk_busy (NUM_READ packed combinational lookups).
module regfile_scoreboard #(
    parameter int NUM_REGS   = 32,
    parameter int NUM_READ   = 2,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           set_en,
    input  logic [ADDR_WIDTH-1:0]          set_addr,
    input  logic                           clr_en,
    input  logic [ADDR_WIDTH-1:0]          clr_addr,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] lk_addr,
    output logic [NUM_READ-1:0]            lk_busy
);

    logic [NUM_REGS-1:0] busy;

    // Set beats clear so a new producer issued alongside the old
    // producer's writeback keeps the register marked busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (set_en && (set_addr == ADDR_WIDTH'(i)))
                    busy[i] <= 1'b1;
                else if (clr_en && (clr_addr == ADDR_WIDTH'(i)))
                    busy[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        lk_busy = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (lk_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i))
                    lk_busy[p] = busy[i];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with busy scoreboard and a
// one-register-per-cycle clear sweep. Optional macro: REGFILE_BYPASS_EN.
// Ports: clk, rst_n, rd_addr_i/rd_data_o/rd_busy_o (packed read ports),
// we_i/waddr_i/wdata_i (write), issue_i/issue_addr_i, clr_req_i, clr_busy_o.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data_o,
    output logic [NUM_READ-1:0]            rd_busy_o,
    input  logic                           we_i,
    input  logic [ADDR_WIDTH-1:0]          waddr_i,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic                           issue_i,
    input  logic [ADDR_WIDTH-1:0]          issue_addr_i,
    input  logic                           clr_req_i,
    output logic                           clr_busy_o
);

    localparam int unsigned NREGS = NUM_REGS;
    localparam logic        ZR    = (ZERO_REG != 0);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  sweep;
    logic                  wr_ok, iss_ok;
    logic                  sb_clr_en;
    logic [ADDR_WIDTH-1:0] sb_clr_addr;
    logic [NUM_READ-1:0]   sb_busy;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    assign wr_ok  = accept_ok(state == IDLE, we_i,
                              32'(waddr_i), NREGS, ZR);
    assign iss_ok = accept_ok(state == IDLE, issue_i,
                              32'(issue_addr_i), NREGS, ZR);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (clr_req_i) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == ADDR_WIDTH'(NUM_REGS - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        sweep      = (state == CLEAR);
        clr_busy_o = sweep;
    end

    // The sweep and writeback share the scoreboard clear port; they
    // never coincide because writes are refused while sweeping.
    assign sb_clr_en   = sweep | wr_ok;
    assign sb_clr_addr = sweep ? cnt : waddr_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (sweep && (cnt == ADDR_WIDTH'(i)))
                    regs[i] <= '0;
                else if (wr_ok && (waddr_i == ADDR_WIDTH'(i)))
                    regs[i] <= wdata_i;
            end
        end
    end

    regfile_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .NUM_READ   (NUM_READ),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (iss_ok),
        .set_addr (issue_addr_i),
        .clr_en   (sb_clr_en),
        .clr_addr (sb_clr_addr),
        .lk_addr  (rd_addr_i),
        .lk_busy  (sb_busy)
    );

    always_comb begin
        logic [ADDR_WIDTH-1:0] ra;
        ra        = '0;
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            ra = rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ra == ADDR_WIDTH'(i) && !(ZR && i == 0))
                    rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = regs[i];
            end
            rd_busy_o[p] = sb_busy[p];
`ifdef REGFILE_BYPASS_EN
            // wr_ok already implies IDLE, so no bypass during a sweep.
            if (wr_ok && (ra == waddr_i)) begin
                rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = wdata_i;
                rd_busy_o[p] = iss_ok && (issue_addr_i == waddr_i);
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp with a queued scoreboard.
// Stimulus pushes expectations tagged by cycle; a monitor checks them.
module tb_regfile_mp;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]  rd_busy;
    logic           we;
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  wdata;
    logic           issue;
    logic [AW-1:0]  issue_addr;
    logic           clr_req;
    logic           clr_busy;

    regfile_mp dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_busy_o    (rd_busy),
        .we_i         (we),
        .waddr_i      (waddr),
        .wdata_i      (wdata),
        .issue_i      (issue),
        .issue_addr_i (issue_addr),
        .clr_req_i    (clr_req),
        .clr_busy_o   (clr_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          cyc;
        int          kind;
        int          port;
        logic [31:0] exp;
    } item_t;

    item_t q[$];
    int    cyc = 0;
    int    n_vec = 0;
    int    n_bad = 0;
    logic  done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            item_t       it;
            logic [31:0] act;
            it = q.pop_front();
            case (it.kind)
                0:       act = rd_data[it.port*DW +: DW];
                1:       act = 32'(rd_busy[it.port]);
                default: act = 32'(clr_busy);
            endcase
            n_vec++;
            if (act !== it.exp) begin
                n_bad++;
                $display("FAIL %s (cyc %0d): got %h expected %h",
                         it.name, cyc, act, it.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic exp_d(input string n, input int p, input logic [31:0] e);
        q.push_back('{n, cyc, 0, p, e});
    endtask

    task automatic exp_b(input string n, input int p, input logic e);
        q.push_back('{n, cyc, 1, p, 32'(e)});
    endtask

    task automatic exp_c(input string n, input logic e);
        q.push_back('{n, cyc, 2, 0, 32'(e)});
    endtask

    task automatic idle_in();
        we = 0; issue = 0; clr_req = 0;
    endtask

    task automatic fill();
        for (int i = 0; i < 32; i++) begin
            we = 1; waddr = AW'(i); wdata = 32'(i);
            issue = (i == 31); issue_addr = 5'd30;
            step();
        end
        idle_in();
    endtask

    logic byp;

    initial begin
`ifdef REGFILE_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        rst_n = 0; rd_addr = '0; we = 0; waddr = '0; wdata = '0;
        issue = 0; issue_addr = '0; clr_req = 0;
        step(); step();
        set_rd(0, 5); set_rd(1, 3);
        exp_d("rst_d0", 0, 0); exp_d("rst_d1", 1, 0);
        exp_b("rst_b0", 0, 0); exp_c("rst_clr", 0);
        step();
        rst_n = 1;
        step();
        n_vec++;
        if (rd_data !== '0) begin
            n_bad++;
            $display("FAIL inl_rst: got %h expected 0", rd_data);
        end

        we = 1; waddr = 5; wdata = 32'hDEADBEEF;
        set_rd(0, 5); set_rd(1, 0);
        step();
        we = 0;
        n_vec++;
        if (rd_data[DW-1:0] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL inl_wr5: got %h expected deadbeef",
                     rd_data[DW-1:0]);
        end
        exp_d("wr5", 0, 32'hDEADBEEF); exp_d("r0_zero", 1, 0);
        we = 1; waddr = 0; wdata = 32'h1234;
        issue = 1; issue_addr = 0;
        step();
        idle_in();
        exp_d("r0_after_wr", 1, 0); exp_b("r0_busy", 1, 0);
        step();

        issue = 1; issue_addr = 7; set_rd(0, 7);
        exp_b("iss7_c0", 0, 0);
        step();
        issue = 0;
        exp_b("iss7_c1", 0, 1);
        step();
        exp_b("iss7_c2", 0, 1);
        step();
        we = 1; waddr = 7; wdata = 32'h77;
        exp_b("iss7_c3", 0, !byp);
        step();
        we = 0;
        exp_b("iss7_c4", 0, 0); exp_d("wr7", 0, 32'h77);
        we = 1; waddr = 9; wdata = 32'h99;
        issue = 1; issue_addr = 9; set_rd(1, 9);
        exp_d("same9_c0_d", 1, byp ? 32'h99 : 32'h0);
        exp_b("same9_c0_b", 1, byp);
        step();
        exp_d("same9_d", 1, 32'h99); exp_b("same9_b", 1, 1);
        we = 1; waddr = 10; wdata = 32'hAA;
        issue = 1; issue_addr = 11;
        step();
        idle_in();
        set_rd(0, 10); set_rd(1, 11);
        exp_d("diff_d10", 0, 32'hAA); exp_b("diff_b10", 0, 0);
        exp_b("diff_b11", 1, 1);
        step();

        we = 1; waddr = 12; wdata = 32'hA5; set_rd(1, 12);
        exp_d("byp12_c0", 1, byp ? 32'hA5 : 32'h0);
        step();
        we = 0;
        exp_d("byp12_c1", 1, 32'hA5);
        step();

        fill();
        set_rd(0, 3); set_rd(1, 30);
        exp_d("fill3", 0, 3); exp_b("fill_b30", 1, 1);
        exp_c("clr_pre", 0);
        clr_req = 1;
        step();
        clr_req = 0;
        set_rd(1, 20);
        for (int j = 0; j < 32; j++) begin
            exp_c($sformatf("clr_hi%0d", j), 1);
            exp_d($sformatf("sw3_%0d", j), 0, (j >= 4) ? 32'd0 : 32'd3);
            exp_d($sformatf("sw20_%0d", j), 1, (j >= 21) ? 32'd0 : 32'd20);
            if (j == 30) begin
                we = 1; waddr = 29; wdata = 32'h55;
                issue = 1; issue_addr = 29;
            end else begin
                we = 0; issue = 0;
            end
            step();
        end
        idle_in();
        exp_c("clr_lo", 0);
        for (int i = 0; i < 16; i++) begin
            set_rd(0, i); set_rd(1, i + 16);
            exp_d($sformatf("end_d%0d", i), 0, 0);
            exp_d($sformatf("end_d%0d", i + 16), 1, 0);
            exp_b($sformatf("end_b%0d", i + 16), 1, 0);
            step();
        end

        fill();
        clr_req = 1;
        step();
        clr_req = 0;
        set_rd(0, 20); set_rd(1, 30);
        for (int j = 0; j < 10; j++) begin
            exp_c($sformatf("rs_hi%0d", j), 1);
            step();
        end
        exp_d("pre_rst_d20", 0, 20); exp_b("pre_rst_b30", 1, 1);
        step();
        rst_n = 0;
        exp_d("rst_d20", 0, 0); exp_d("rst_d30", 1, 0);
        exp_b("rst_b30", 1, 0); exp_c("rst_clr_lo", 0);
        step();
        rst_n = 1;
        step();
        set_rd(0, 25);
        exp_c("post_rst_clr", 0); exp_d("post_rst_d25", 0, 0);
        step();
        n_vec++;
        if (clr_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL inl_clr: got %b expected 0", clr_busy);
        end
        step();
        done = 1'b1;
    end

    initial begin
        fork
            wait (done);
            begin
                repeat (2000) @(posedge clk);
                n_bad++;
                $display("FAIL timeout: got running expected done");
            end
        join_any
        disable fork;
        @(posedge clk);
        while (q.size() > 0) begin
            item_t it;
            it = q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s: got unchecked expected checked", it.name);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with an integrated busy scoreboard and a sequential clear engine, for the integer datapath. It keeps the single synchronous write port and asynchronous reads, and adds:
- a configurable number of read ports and registers;
- per-register pending-write tracking for multi-cycle producers;
- a software-triggered sweep that zeroes the array one register per cycle.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers (≥2)
- DATA_WIDTH, 32, register width in bits
- NUM_READ, 2, number of independent read ports (≥1)
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and never busy; 0 = register 0 is an ordinary register
- ADDR_WIDTH, $clog2(NUM_REGS), derived address width; not to be overridden

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr_i  in  NUM_READ*ADDR_WIDTH  packed read addresses; port p uses slice p
- rd_data_o  out  NUM_READ*DATA_WIDTH  packed read data, combinational
- rd_busy_o  out  NUM_READ  scoreboard bit of each addressed register, combinational
- we_i  in  1  writeback enable
- waddr_i  in  ADDR_WIDTH  writeback address
- wdata_i  in  DATA_WIDTH  writeback data
- issue_i  in  1  marks issue_addr_i as having a write in flight
- issue_addr_i  in  ADDR_WIDTH  destination register being issued
- clr_req_i  in  1  request a full array clear
- clr_busy_o  out  1  clear sweep in progress

## Operation
- Reset (rst_n low, asynchronous):
  - all registers 0;
  - all busy bits 0;
  - FSM IDLE; sweep counter 0;
  - clr_busy_o 0.
- Reads: rd_data_o[p] = regs[rd_addr_i[p]]; rd_busy_o[p] = busy[rd_addr_i[p]].
  - Address ≥ NUM_REGS reads data 0, busy 0.
  - With ZERO_REG=1, address 0 reads data 0, busy 0.
- Write accepted when: FSM is IDLE, we_i=1, waddr_i < NUM_REGS, and not (ZERO_REG=1 and waddr_i=0). An accepted write stores wdata_i and clears busy[waddr_i].
- Issue accepted under the same conditions with issue_i and issue_addr_i; it sets busy[issue_addr_i].
- Issue and write to the same address in the same cycle: data is written and busy ends 1 (the new producer wins).
- Issue and write to different addresses in the same cycle: both take effect.
- FSM states:
  - IDLE: clr_req_i=1 goes to CLEAR with cnt=0.
  - CLEAR: each edge writes regs[cnt]=0 and busy[cnt]=0, then increments cnt. At cnt=NUM_REGS-1 the write completes and the FSM returns to IDLE.
- During CLEAR:
  - we_i and issue_i are ignored (the producer must retry);
  - clr_req_i is ignored;
  - reads return current, partially cleared contents.
- Reset asserted mid-sweep aborts the sweep; the reset state applies.

## Timing
- Write latency: data visible on reads the cycle after the accepting edge (zero cycles with bypass, see Configuration).
- Busy set or cleared at the accepting edge, visible the following cycle.
- Clear: clr_req_i sampled high at edge k. clr_busy_o is high from after edge k until after edge k+NUM_REGS, i.e. exactly NUM_REGS cycles. Register i is zeroed at edge k+1+i.
- clr_req_i held high continuously: a new sweep starts at the edge after clr_busy_o falls.

## Configuration
- REGFILE_BYPASS_EN defined:
  - a read port whose address equals waddr_i while a write is accepted this cycle returns wdata_i;
  - it returns busy 0, unless issue_i hits the same address, in which case busy is 1.
  - No bypass while in CLEAR.
- REGFILE_BYPASS_EN undefined: reads always return stored state; the new value is visible next cycle.

## Structure
- Package regfile_pkg: FSM state enum (IDLE, CLEAR) and the helper function computing the write/issue accept conditions.
- Sub-module regfile_scoreboard: NUM_REGS busy bits with set (issue), clear (write, sweep) and NUM_READ lookup ports. The top holds the data array, read muxes, bypass and sweep FSM.

## Test plan
- Reset, then write 0xDEADBEEF to reg 5 → next cycle port 0 at addr 5 reads 0xDEADBEEF; port 1 at addr 0 reads 0 (ZERO_REG=1).
- Write 0x1234 to reg 0 with ZERO_REG=1 → reg 0 still reads 0; issue to reg 0 → busy stays 0.
- Issue reg 7, then write reg 7 three cycles later → rd_busy_o is 1 for cycles 1–3 and 0 after; same-cycle issue and write on reg 9 → busy 1, data updated.
- Fill all registers with their index, pulse clr_req_i → clr_busy_o is high for exactly 32 cycles; reg 3 reads 0 from edge k+4; a we_i during the sweep is dropped; all registers read 0 at the end.
- Assert rst_n low at sweep cycle 10 → all registers and busy bits read 0 immediately, clr_busy_o is 0.
- With REGFILE_BYPASS_EN, write 0xA5 to reg 12 while port 1 reads 12 → same cycle rd_data_o[1]=0xA5. Without the macro → old value, then 0xA5 the next cycle.
